// File: rtl/morse_message_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | morse_message_controller: 4-deep letter FIFO feeding a Morse serialiser.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module morse_message_controller #(
  parameter int CLOCK_FREQUENCY = 500
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Push,
  input  logic [2:0] Letter,
  input  logic       Start,
  output logic       DotDashOut,
  output logic       NewBitOut,
  output logic       Busy,
  output logic       Full,
  output logic       Done
);
  localparam int HALF   = CLOCK_FREQUENCY / 2;
  localparam int TICK_W = $clog2(HALF) + 1;
  localparam logic [TICK_W-1:0] c_tick_reload = TICK_W'(HALF - 1);
  localparam logic [TICK_W-1:0] c_tick_one    = TICK_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            r_state;
  logic [2:0]        r_fifo [4];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_count;
  logic [11:0]       r_shifter;
  logic [3:0]        r_bit_cnt;
  logic [1:0]        r_gap_cnt;
  logic [TICK_W-1:0] r_tick;

  logic              w_pop;
  logic              w_push;
  logic [11:0]       w_head_pattern;

  function automatic logic [11:0] letter_pattern(input logic [2:0] code);
    logic [11:0] p;
    case (code)
      3'd0:    p = 12'b101110000000;
      3'd1:    p = 12'b111010101000;
      3'd2:    p = 12'b111010111010;
      3'd3:    p = 12'b111010100000;
      3'd4:    p = 12'b100000000000;
      3'd5:    p = 12'b101011101000;
      3'd6:    p = 12'b111011101000;
      default: p = 12'b101010100000;
    endcase
    return p;
  endfunction

  // LOAD is only ever entered with count > 0, so the pop never underflows.
  // A push on a full FIFO still lands when the head is popped in the same cycle.
  assign w_pop          = (r_state == LOAD);
  assign w_push         = Push && !Reset && ((r_count != 3'd4) || w_pop);
  assign w_head_pattern = letter_pattern(r_fifo[r_rd_ptr]);
  assign Full           = (r_count == 3'd4);

  always_ff @(posedge ClockIn) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= Letter;
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_shifter  <= 12'd0;
      r_bit_cnt  <= 4'd0;
      r_gap_cnt  <= 2'd0;
      r_tick     <= '0;
      DotDashOut <= 1'b0;
      NewBitOut  <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      NewBitOut <= 1'b0;
      Done      <= 1'b0;
      case (r_state)
        IDLE: begin
          DotDashOut <= 1'b0;
          if (Start && (r_count != 3'd0)) begin
            r_state <= LOAD;
            Busy    <= 1'b1;
          end
        end
        LOAD: begin
          r_shifter  <= w_head_pattern;
          r_bit_cnt  <= 4'd11;
          r_tick     <= c_tick_reload;
          DotDashOut <= w_head_pattern[11];
          NewBitOut  <= 1'b1;
          r_state    <= SHIFT;
        end
        SHIFT: begin
          if (r_tick != '0) begin
            r_tick <= r_tick - c_tick_one;
          end else if (r_bit_cnt != 4'd0) begin
            r_shifter  <= {r_shifter[10:0], 1'b0};
            r_bit_cnt  <= r_bit_cnt - 4'd1;
            r_tick     <= c_tick_reload;
            DotDashOut <= r_shifter[10];
            NewBitOut  <= 1'b1;
          end else if (r_count != 3'd0) begin
            r_state    <= GAP;
            r_tick     <= c_tick_reload;
            r_gap_cnt  <= 2'd2;
            DotDashOut <= 1'b0;
          end else begin
            r_state    <= DONE;
            Done       <= 1'b1;
            DotDashOut <= 1'b0;
          end
        end
        GAP: begin
          DotDashOut <= 1'b0;
          if (r_tick != '0) begin
            r_tick <= r_tick - c_tick_one;
          end else if (r_gap_cnt != 2'd0) begin
            r_gap_cnt <= r_gap_cnt - 2'd1;
            r_tick    <= c_tick_reload;
          end else begin
            r_state <= LOAD;
          end
        end
        DONE: begin
          DotDashOut <= 1'b0;
          Busy       <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          DotDashOut <= 1'b0;
          Busy       <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_morse_message_controller.sv
`default_nettype none
// Bench for morse_message_controller: directed scenarios plus random traffic,
// checked every cycle against a timeline model built from Morse dot/dash rules.
module tb_morse_message_controller;
  localparam int CLOCK_FREQUENCY = 8;
  localparam int HALF = CLOCK_FREQUENCY / 2;

  logic       ClockIn = 1'b0;
  logic       Reset = 1'b0;
  logic       Push = 1'b0;
  logic [2:0] Letter = 3'd0;
  logic       Start = 1'b0;
  logic       DotDashOut, NewBitOut, Busy, Full, Done;

  int total = 0;
  int bad = 0;
  logic [4:0] obs;

  morse_message_controller #(.CLOCK_FREQUENCY(CLOCK_FREQUENCY)) dut (
    .ClockIn(ClockIn), .Reset(Reset), .Push(Push), .Letter(Letter), .Start(Start),
    .DotDashOut(DotDashOut), .NewBitOut(NewBitOut), .Busy(Busy), .Full(Full), .Done(Done)
  );

  always #5 ClockIn = ~ClockIn;

  // Model: letter queue plus a position m_t inside the current letter slot
  // (0 = load cycle, 1..12*HALF = symbol cycles, then 3*HALF gap cycles).
  logic [2:0]  m_q[$];
  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_t = 0;
  logic [11:0] m_pat = '0;

  // dot = on 1 unit + off 1 unit, dash = on 3 units + off 1 unit, zero padded
  function automatic logic [11:0] morse_pattern(input int code);
    string s;
    logic [11:0] p;
    int pos;
    byte c;
    case (code)
      0: s = ".-";   1: s = "-...";  2: s = "-.-.";  3: s = "-..";
      4: s = ".";    5: s = "..-.";  6: s = "--.";   default: s = "....";
    endcase
    p = '0;
    pos = 11;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == "-") begin
        p[pos] = 1'b1; p[pos-1] = 1'b1; p[pos-2] = 1'b1;
        pos -= 4;
      end else begin
        p[pos] = 1'b1;
        pos -= 2;
      end
    end
    return p;
  endfunction

  task automatic model_edge(input bit p, input bit [2:0] l, input bit s, input bit r);
    int size_pre;
    bit popped;
    if (r) begin
      m_q.delete(); m_busy = 0; m_done = 0; m_t = 0;
      return;
    end
    size_pre = m_q.size();
    popped = 0;
    if (!m_busy) begin
      if (s && size_pre > 0) begin m_busy = 1; m_t = 0; end
    end else if (m_done) begin
      m_busy = 0; m_done = 0;
    end else if (m_t == 0) begin
      m_pat = morse_pattern(int'(m_q.pop_front()));
      popped = 1;
      m_t = 1;
    end else if (m_t == 12 * HALF) begin
      if (size_pre > 0) m_t++;
      else m_done = 1;
    end else if (m_t == 15 * HALF) begin
      m_t = 0;
    end else begin
      m_t++;
    end
    if (p && (size_pre < 4 || popped)) m_q.push_back(l);
  endtask

  function automatic logic [4:0] model_out();
    logic dd, nb;
    int b;
    dd = 1'b0;
    nb = 1'b0;
    if (m_busy && !m_done && m_t >= 1 && m_t <= 12 * HALF) begin
      b  = (m_t - 1) / HALF;
      dd = m_pat[11 - b];
      nb = ((m_t - 1) % HALF) == 0;
    end
    return {dd, nb, m_busy, m_q.size() == 4, m_done};
  endfunction

  task automatic cycle(input bit p, input bit [2:0] l, input bit s, input bit r);
    Push = p; Letter = l; Start = s; Reset = r;
    @(posedge ClockIn);
    #1;
    model_edge(p, l, s, r);
    obs = {DotDashOut, NewBitOut, Busy, Full, Done};
  endtask

  task automatic test_reset();
    cycle(1, 3'd3, 1, 1);
    cycle(1, 3'd5, 1, 1);
    total++;
    if (obs !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got=%b want=%b", obs, 5'b0);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 3'd0, 1, 0);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, obs, model_out());
      end
    end
  endtask

  task automatic test_single_a();
    int done_at, pulses;
    done_at = -1;
    pulses = 0;
    cycle(1, 3'd0, 0, 0);
    cycle(0, 3'd0, 1, 0);
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) cycle(0, 3'd0, 0, 0);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL single_a cyc=%0d got=%b want=%b", n, obs, model_out());
      end
      if (NewBitOut === 1'b1) pulses++;
      if (Done === 1'b1 && done_at < 0) done_at = n;
    end
    total++;
    if (done_at !== 50) begin
      bad++; $display("FAIL single_a_done_cycle got=%0d want=%0d", done_at, 50);
    end
    total++;
    if (pulses !== 12) begin
      bad++; $display("FAIL single_a_newbits got=%0d want=%0d", pulses, 12);
    end
  endtask

  task automatic test_gap_pair();
    int pulses, dones;
    pulses = 0;
    dones = 0;
    cycle(1, 3'd4, 0, 0);
    cycle(1, 3'd4, 0, 0);
    cycle(0, 3'd0, 1, 0);
    for (int n = 1; n <= 120; n++) begin
      if (n > 1) cycle(0, 3'd0, 0, 0);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL gap_pair cyc=%0d got=%b want=%b", n, obs, model_out());
      end
      if (NewBitOut === 1'b1) pulses++;
      if (Done === 1'b1) dones++;
    end
    total++;
    if (pulses !== 24 || dones !== 1) begin
      bad++; $display("FAIL gap_pair_counts got=%0d/%0d want=24/1", pulses, dones);
    end
  endtask

  task automatic test_overflow();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 3'($urandom_range(0, 7)), 0, 0);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL overflow_push i=%0d got=%b want=%b", i, obs, model_out());
      end
    end
    total++;
    if (Full !== 1'b1) begin
      bad++; $display("FAIL overflow_full got=%b want=1", Full);
    end
    cycle(0, 3'd0, 1, 0);
    for (int n = 1; n <= 260; n++) begin
      if (n > 1) cycle(0, 3'd0, 0, 0);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL overflow_run cyc=%0d got=%b want=%b", n, obs, model_out());
      end
      if (NewBitOut === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 48) begin
      bad++; $display("FAIL overflow_newbits got=%0d want=%0d", pulses, 48);
    end
  endtask

  task automatic test_empty_start();
    for (int i = 0; i < 10; i++) begin
      cycle(0, 3'd0, 1, 0);
      total++;
      if (obs !== model_out() || Busy !== 1'b0) begin
        bad++; $display("FAIL empty_start cyc=%0d got=%b want=%b", i, obs, model_out());
      end
    end
    cycle(1, 3'd3, 0, 0);
    cycle(0, 3'd0, 1, 0);
    for (int n = 1; n <= 70; n++) begin
      if (n > 1) cycle(0, 3'd0, n == 20, 0);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL busy_start cyc=%0d got=%b want=%b", n, obs, model_out());
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 3'd2, 0, 0);
    cycle(0, 3'd0, 1, 0);
    for (int n = 1; n < 20; n++) begin
      if (n > 1) cycle(0, 3'd0, 0, 0);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL reset_mid_run cyc=%0d got=%b want=%b", n, obs, model_out());
      end
    end
    cycle(0, 3'd0, 0, 1);
    total++;
    if (obs !== 5'b0) begin
      bad++; $display("FAIL reset_mid_outputs got=%b want=%b", obs, 5'b0);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 3'd0, 1, 0);
      total++;
      if (obs !== model_out() || Busy !== 1'b0) begin
        bad++; $display("FAIL reset_mid_start cyc=%0d got=%b want=%b", i, obs, model_out());
      end
    end
  endtask

  task automatic test_back_to_back();
    cycle(1, 3'd0, 0, 0);
    cycle(0, 3'd0, 1, 0);
    for (int n = 1; n <= 130; n++) begin
      if (n > 1) cycle(n == 29, 3'd1, 0, 0);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL push_during cyc=%0d got=%b want=%b", n, obs, model_out());
      end
    end
    for (int i = 0; i < 4; i++) cycle(1, 3'($urandom_range(0, 7)), 0, 0);
    cycle(0, 3'd0, 1, 0);
    cycle(1, 3'd6, 0, 0);
    total++;
    if (Full !== 1'b1) begin
      bad++; $display("FAIL push_pop_full got=%b want=1", Full);
    end
    for (int n = 0; n < 320; n++) begin
      cycle(0, 3'd0, 0, 0);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL push_pop_run cyc=%0d got=%b want=%b", n, obs, model_out());
      end
    end
  endtask

  task automatic test_random();
    bit p, s, r;
    bit [2:0] l;
    for (int i = 0; i < 4000; i++) begin
      p = ($urandom_range(0, 11) == 0);
      l = 3'($urandom_range(0, 7));
      s = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 799) == 0);
      cycle(p, l, s, r);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, obs, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_gap_pair();
    test_overflow();
    test_empty_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
